// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the register-hazard scoreboard between decode and execute.
package issue_scoreboard_pkg;

  // Architectural MIPS register number.
  typedef logic [4:0] MipsReg;

  // Issue controller states: normal issue, or waiting for the pipeline to empty.
  typedef enum logic [0:0] {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } SbState;

  localparam int SB_NUM_REGS = 32;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// One saturating in-flight write counter for a single architectural register.
// Up to one increment and two decrements (writeback + kill) per cycle; the
// result is clamped to [0, 2^CNT_W-1] and err_o flags a clamp this cycle.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [1:0]       dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [CNT_W+2:0] sum_s;
  logic                    err_s;

  // Net the increment against both decrements, then clamp into range.
  always_comb begin
    sum_s = $signed({3'b000, cnt_q})
          + $signed({{(CNT_W + 2){1'b0}}, inc_i})
          - $signed({{(CNT_W + 1){1'b0}}, dec_i});
    cnt_d = cnt_q;
    err_s = 1'b0;
    if (sum_s < $signed({(CNT_W + 3){1'b0}})) begin
      cnt_d = {CNT_W{1'b0}};
      err_s = 1'b1;
    end else if (sum_s > $signed({3'b000, CNT_MAX})) begin
      cnt_d = CNT_MAX;
      err_s = 1'b1;
    end else begin
      cnt_d = sum_s[CNT_W-1:0];
      err_s = 1'b0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == {CNT_W{1'b0}});
  assign full_o  = (cnt_q == CNT_MAX);
  assign err_o   = err_s;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks pending writes per register, stalls on RAW hazards or a saturated
// destination counter, and serializes instructions needing an empty pipeline.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_uses_rs,
  input  logic        i_uses_rt,
  input  logic        i_uses_rw,
  input  MipsReg      i_rs_addr,
  input  MipsReg      i_rt_addr,
  input  MipsReg      i_rw_addr,
  input  logic        i_serialize,
  input  logic        i_ex_ready,
  input  logic        i_wb_valid,
  input  MipsReg      i_wb_addr,
  input  logic        i_kill_valid,
  input  MipsReg      i_kill_addr,
  output logic        o_issue,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_err,
  output logic [31:0] o_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam MipsReg           REG_ZERO = 5'd0;

  logic [CNT_W-1:0]       cnt_s [SB_NUM_REGS];
  logic [1:0]             dec_s [SB_NUM_REGS];
  logic [SB_NUM_REGS-1:0] zero_s, full_s, err_s, inc_s, byp_s;

  SbState      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        issue_s, busy_s, hazard_s;
  logic        rs_pend_s, rt_pend_s, rw_full_s;

  // Register 0 is never tracked: it always reads as empty.
  assign cnt_s[0]  = {CNT_W{1'b0}};
  assign zero_s[0] = 1'b1;
  assign full_s[0] = 1'b0;
  assign err_s[0]  = 1'b0;

  for (genvar r = 1; r < SB_NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_s[r]),
      .dec_i   (dec_s[r]),
      .count_o (cnt_s[r]),
      .zero_o  (zero_s[r]),
      .full_o  (full_s[r]),
      .err_o   (err_s[r])
    );
  end

  // Decode issue/writeback/kill into per-register increment, decrement and bypass.
  always_comb begin
    for (int r = 0; r < SB_NUM_REGS; r++) begin
      inc_s[r] = (r != 0) & issue_s & i_uses_rw & (i_rw_addr == MipsReg'(r));
      dec_s[r] = {1'b0, (r != 0) & i_wb_valid & (i_wb_addr == MipsReg'(r))}
               + {1'b0, (r != 0) & i_kill_valid & (i_kill_addr == MipsReg'(r))};
      byp_s[r] = WB_BYPASS & (dec_s[r] != 2'd0);
    end
  end

  // Hazard check: a same-cycle retirement to a source counts as one less pending write.
  always_comb begin
    rs_pend_s = i_uses_rs & (i_rs_addr != REG_ZERO) &
                (byp_s[i_rs_addr] ? (cnt_s[i_rs_addr] > CNT_ONE) : !zero_s[i_rs_addr]);
    rt_pend_s = i_uses_rt & (i_rt_addr != REG_ZERO) &
                (byp_s[i_rt_addr] ? (cnt_s[i_rt_addr] > CNT_ONE) : !zero_s[i_rt_addr]);
    rw_full_s = i_uses_rw & (i_rw_addr != REG_ZERO) & full_s[i_rw_addr];
    hazard_s  = rs_pend_s | rt_pend_s | rw_full_s;
    busy_s    = |(~zero_s);
  end

  // Issue FSM next-state and issue decision; DRAIN waits for an empty scoreboard.
  always_comb begin
    state_d = state_q;
    issue_s = 1'b0;
    case (state_q)
      SB_RUN: begin
        issue_s = i_valid & !hazard_s & i_ex_ready & !(i_serialize & busy_s);
        if (i_valid & i_serialize & busy_s) begin
          state_d = SB_DRAIN;
        end else begin
          state_d = SB_RUN;
        end
      end
      SB_DRAIN: begin
        issue_s = i_valid & !hazard_s & i_ex_ready & !busy_s;
        if (issue_s) begin
          state_d = SB_RUN;
        end else begin
          state_d = SB_DRAIN;
        end
      end
      default: begin
        state_d = SB_RUN;
        issue_s = 1'b0;
      end
    endcase
  end

  // Next values for the sticky error flag and the wrapping stall counter.
  always_comb begin
    err_d          = err_q | (|err_s);
    stall_cycles_d = stall_cycles_q;
    if (o_stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State, error and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SB_RUN;
      err_q          <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_issue        = issue_s;
  assign o_stall        = i_valid & !issue_s;
  assign o_busy         = busy_s;
  assign o_err          = err_q;
  assign o_stall_cycles = stall_cycles_q;

endmodule
